// File: rtl/keypad_scanner_db.sv
// Matrix-keypad scanner: walks active-low columns, samples synchronised rows once per
// column, classifies each full frame and debounces it into a key index with press/release strobes.
module keypad_scanner_db #(
   parameter int NROWS        = 4,
   parameter int NCOLS        = 4,
   parameter int DWELL_CYC    = 50000,
   parameter int SETTLE_CYC   = 8,
   parameter int DEBOUNCE_FRM = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NROWS-1:0]               row_n,
   output logic [NCOLS-1:0]               col_n,
   output logic [$clog2(NROWS*NCOLS)-1:0] key_idx,
   output logic                           key_held,
   output logic                           key_press,
   output logic                           key_release
);
   localparam int KEYS = NROWS * NCOLS;
   localparam int KW   = $clog2(KEYS);
   localparam int DW   = $clog2(DWELL_CYC);
   localparam int CW   = (NCOLS > 1) ? $clog2(NCOLS) : 1;
   localparam int NW   = $clog2(DEBOUNCE_FRM + 1);

   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYC - 1);
   localparam logic [DW-1:0] SETTLE_AT  = DW'(SETTLE_CYC);
   localparam logic [CW-1:0] COL_LAST   = CW'(NCOLS - 1);
   localparam logic [NW-1:0] CNT_MAX    = NW'(DEBOUNCE_FRM);

   logic [NROWS-1:0] row_s1_q, row_s2_q;
   logic [NCOLS-1:0] col_n_q, col_n_d;
   logic [CW-1:0]    col_q, col_d;
   logic [DW-1:0]    dwell_q, dwell_d;
   logic [KEYS-1:0]  frame_q, frame_d;
   logic             prev_hit_q, prev_hit_d;
   logic [KW-1:0]    prev_key_q, prev_key_d;
   logic [NW-1:0]    cnt_q, cnt_d;
   logic [KW-1:0]    key_idx_q, key_idx_d;
   logic             held_q, held_d;
   logic             press_q, press_d;
   logic             release_q, release_d;

   logic             hit_any, hit_multi;
   logic [KW-1:0]    cand;
   logic             scanning, frame_end, same, accept;
   logic [NW-1:0]    cnt_nxt;

   // Frame bit r*NCOLS+c is set when that key was seen closed; classify NONE/SINGLE/MULTI.
   always_comb begin
      hit_any   = 1'b0;
      hit_multi = 1'b0;
      cand      = '0;
      for (int i = 0; i < KEYS; i++) begin
         if (frame_q[i]) begin
            if (hit_any) hit_multi = 1'b1;
            hit_any = 1'b1;
            cand    = KW'(i);
         end
      end
   end

   always_comb begin
      scanning   = ~&col_n_q;
      col_d      = col_q;
      dwell_d    = dwell_q;
      frame_d    = frame_q;
      prev_hit_d = prev_hit_q;
      prev_key_d = prev_key_q;
      cnt_d      = cnt_q;
      key_idx_d  = key_idx_q;
      held_d     = held_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      frame_end  = 1'b0;
      same       = 1'b0;
      accept     = 1'b0;
      cnt_nxt    = cnt_q;

      if (scanning) begin
         if (dwell_q == SETTLE_AT) begin
            for (int r = 0; r < NROWS; r++) begin
               for (int c = 0; c < NCOLS; c++) begin
                  if (col_q == CW'(c)) frame_d[r*NCOLS + c] = ~row_s2_q[r];
               end
            end
         end
         if (dwell_q == DWELL_LAST) begin
            dwell_d   = '0;
            frame_end = (col_q == COL_LAST);
            col_d     = frame_end ? '0 : col_q + 1'b1;
         end else begin
            dwell_d = dwell_q + 1'b1;
         end
      end

      // Ghosted (MULTI) frames are ignored entirely: history and counter stay put.
      if (frame_end && !hit_multi) begin
         same       = (hit_any == prev_hit_q) && (cand == prev_key_q);
         cnt_nxt    = !same ? NW'(1) : (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
         accept     = (cnt_nxt == CNT_MAX) && !(same && (cnt_q == CNT_MAX));
         cnt_d      = cnt_nxt;
         prev_hit_d = hit_any;
         prev_key_d = cand;
         if (accept) begin
            if (hit_any) begin
               if (!held_q || (key_idx_q != cand)) begin
                  key_idx_d = cand;
                  held_d    = 1'b1;
                  press_d   = 1'b1;
               end
            end else if (held_q) begin
               held_d    = 1'b0;
               release_d = 1'b1;
            end
         end
      end
   end

   always_comb begin
      for (int c = 0; c < NCOLS; c++) col_n_d[c] = (col_d != CW'(c));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_s1_q   <= '1;
         row_s2_q   <= '1;
         col_n_q    <= '1;
         col_q      <= '0;
         dwell_q    <= '0;
         frame_q    <= '0;
         prev_hit_q <= 1'b0;
         prev_key_q <= '0;
         cnt_q      <= '0;
         key_idx_q  <= '0;
         held_q     <= 1'b0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
      end else begin
         row_s1_q   <= row_n;
         row_s2_q   <= row_s1_q;
         col_n_q    <= col_n_d;
         col_q      <= col_d;
         dwell_q    <= dwell_d;
         frame_q    <= frame_d;
         prev_hit_q <= prev_hit_d;
         prev_key_q <= prev_key_d;
         cnt_q      <= cnt_d;
         key_idx_q  <= key_idx_d;
         held_q     <= held_d;
         press_q    <= press_d;
         release_q  <= release_d;
      end
   end

   assign col_n       = col_n_q;
   assign key_idx     = key_idx_q;
   assign key_held    = held_q;
   assign key_press   = press_q;
   assign key_release = release_q;

endmodule

// File: tb/tb_keypad_scanner_db.sv
// Bench for keypad_scanner_db: emulates a keypad matrix, predicts debounced events per frame
// and checks them from a separate monitor, alongside the column scan sequence.
module tb_keypad_scanner_db;
   localparam int NROWS = 4;
   localparam int NCOLS = 4;
   localparam int DWELL = 16;
   localparam int SETTLE = 4;
   localparam int DEB = 3;
   localparam int FRAME = NCOLS * DWELL;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NROWS-1:0] row_n;
   logic [NCOLS-1:0] col_n;
   logic [3:0]       key_idx;
   logic             key_held, key_press, key_release;

   logic [15:0] held;
   int          pos_cnt;
   int          checks = 0;
   int          failures = 0;

   typedef struct packed {
      logic       press;
      logic [3:0] idx;
   } ev_t;
   ev_t exp_q[$];

   logic [3:0] m_idx;
   logic       m_held;
   int         run_len;
   bit         m_prev_single;
   int         m_prev_key;

   keypad_scanner_db #(
      .NROWS(NROWS), .NCOLS(NCOLS), .DWELL_CYC(DWELL),
      .SETTLE_CYC(SETTLE), .DEBOUNCE_FRM(DEB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n),
      .key_idx(key_idx), .key_held(key_held),
      .key_press(key_press), .key_release(key_release)
   );

   always #5 clk = ~clk;

   // Passive matrix: a row reads low when a closed key connects it to a driven column.
   always_comb begin
      row_n = '1;
      for (int r = 0; r < NROWS; r++)
         for (int c = 0; c < NCOLS; c++)
            if (held[r*NCOLS + c] && !col_n[c]) row_n[r] = 1'b0;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) pos_cnt <= 0;
      else        pos_cnt <= pos_cnt + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] K(input int n);
      logic [15:0] v;
      v    = '0;
      v[n] = 1'b1;
      return v;
   endfunction

   task automatic model_reset();
      m_idx         = '0;
      m_held        = 1'b0;
      run_len       = 0;
      m_prev_single = 1'b0;
      m_prev_key    = 0;
   endtask

   // Ignore ghosted frames; accept a result when its run of identical frames is exactly DEB long.
   task automatic model_frame(input logic [15:0] s);
      int n, key;
      bit same;
      n   = $countones(s);
      key = 0;
      if (n > 1) return;
      for (int i = 0; i < 16; i++) if (s[i]) key = i;
      same          = ((n == 1) == m_prev_single) && (key == m_prev_key);
      run_len       = same ? run_len + 1 : 1;
      m_prev_single = (n == 1);
      m_prev_key    = key;
      if (run_len == DEB) begin
         if (n == 1) begin
            if (!m_held || m_idx != 4'(key)) begin
               exp_q.push_back({1'b1, 4'(key)});
               m_idx  = 4'(key);
               m_held = 1'b1;
            end
         end else if (m_held) begin
            m_held = 1'b0;
            exp_q.push_back({1'b0, m_idx});
         end
      end
   endtask

   // Safe point to change the key set: last column, after its row sample was taken.
   task automatic wait_apply();
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 4 * FRAME && !hit; i++) begin
         @(negedge clk);
         if (rst_n && pos_cnt > 0 && ((pos_cnt - 1) % FRAME) == FRAME - DWELL + 10) hit = 1'b1;
      end
      if (!hit) begin
         checks++;
         failures++;
         $display("FAIL apply_timeout act=no_frame_point exp=frame_point t=%0t", $time);
      end
   endtask

   task automatic next_frame(input logic [15:0] s);
      wait_apply();
      chk("pending_events", exp_q.size(), 0);
      chk("key_idx_state", key_idx, m_idx);
      chk("key_held_state", key_held, m_held);
      model_frame(held);
      held = s;
   endtask

   always @(negedge clk) begin
      logic [3:0] ec;
      ev_t e;
      if (!rst_n || pos_cnt == 0) begin
         chk("col_n_idle", col_n, 4'hF);
      end else begin
         ec = 4'hF & ~(4'b0001 << (((pos_cnt - 1) / DWELL) % NCOLS));
         chk("col_n_scan", col_n, ec);
      end
      if (rst_n && (key_press || key_release)) begin
         chk("press_release_excl", key_press & key_release, 0);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event act_press=%0d act_release=%0d act_idx=%0d exp=none t=%0t",
                     key_press, key_release, key_idx, $time);
         end else begin
            e = exp_q.pop_front();
            chk("event_kind_press", key_press, e.press);
            chk("event_idx", key_idx, e.idx);
            chk("event_held", key_held, e.press);
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] s;
      int sel, a, b, len;
      bit hit;
      rst_n = 1'b0;
      held  = '0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_key_idx", key_idx, 0);
      chk("rst_key_held", key_held, 0);
      chk("rst_key_press", key_press, 0);
      chk("rst_key_release", key_release, 0);
      rst_n = 1'b1;

      repeat (10) next_frame('0);

      repeat (6) next_frame(K(5));
      repeat (5) next_frame('0);

      for (int i = 0; i < 8; i++) next_frame(((i / 2) % 2) ? K(2) : 16'h0);
      repeat (4) next_frame(K(2));
      repeat (5) next_frame('0);

      repeat (6) next_frame(K(0) | K(15));
      repeat (5) next_frame(K(0));
      repeat (5) next_frame('0);

      repeat (5) next_frame(K(1));
      repeat (5) next_frame(K(6));
      repeat (5) next_frame('0);

      for (int seg = 0; seg < 25; seg++) begin
         sel = $urandom_range(0, 9);
         a   = $urandom_range(0, 15);
         b   = $urandom_range(0, 15);
         s   = '0;
         if (sel >= 3) s[a] = 1'b1;
         if (sel >= 8 && b != a) s[b] = 1'b1;
         len = $urandom_range(1, 5);
         repeat (len) next_frame(s);
      end
      repeat (5) next_frame('0);

      repeat (5) next_frame(K(9));
      hit = 1'b0;
      for (int i = 0; i < 2 * FRAME && !hit; i++) begin
         @(negedge clk);
         if (((pos_cnt - 1) % FRAME) == DWELL + 5) hit = 1'b1;
      end
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_col_n", col_n, 4'hF);
      chk("midrst_key_idx", key_idx, 0);
      chk("midrst_key_held", key_held, 0);
      chk("midrst_key_press", key_press, 0);
      chk("midrst_key_release", key_release, 0);
      chk("midrst_pending", exp_q.size(), 0);
      model_reset();
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) next_frame(K(9));
      repeat (5) next_frame('0);

      wait_apply();
      chk("final_pending", exp_q.size(), 0);
      chk("final_key_held", key_held, m_held);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
